// File: rtl/sl_receiver_pkg.sv
// Shared types for the SL line receiver: FSM encoding and word-mask helper.
package sl_receiver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2,
    ST_ERR   = 2'd3
  } sl_state_e;

  localparam int BCNT_W = 6;

  // Mask keeping the low min(n,32) bits of a received word.
  function automatic logic [31:0] low_mask(input logic [BCNT_W-1:0] n);
    return (n >= BCNT_W'(32)) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
  endfunction

endpackage

// File: rtl/sl_line_sync.sv
// Multi-stage synchronizer for the two SL lines; resets to idle-high.
module sl_line_sync #(
  parameter int STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] line_i,
  output logic [1:0] line_o
);

  logic [STAGES-1:0][1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[STAGES-2:0], line_i};
  end

  assign line_o = sync_q[STAGES-1];

endmodule

// File: rtl/sl_receiver.sv
// SL two-wire receiver: pulse decode, idle-gap word framing, length/odd-parity check,
// sticky status flags.
module sl_receiver
  import sl_receiver_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_PULSE   = 4,
  parameter int GAP_TIMEOUT = 64,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sl0_in,
  input  logic        sl1_in,
  input  logic [5:0]  cfg_bit_qty,
  input  logic        cfg_parity_en,
  input  logic        clr_flags,
  output logic [31:0] rx_data,
  output logic        rx_valid,
  output logic        wrp,
  output logic        wrf,
  output logic        wlc,
  output logic        pef,
  output logic        lef,
  output logic        ovr
);

  logic [1:0] lines;
  logic       s0, s1, one_low, both_low, rel, pulse_ok;

  sl_line_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst    (rst),
    .line_i ({sl1_in, sl0_in}),
    .line_o (lines)
  );

  sl_state_e          state_q, state_d;
  logic               line_q, line_d;    // 1 = pulse on SL1
  logic [CNT_W-1:0]   pcnt_q, pcnt_d, gcnt_q, gcnt_d;
  logic [BCNT_W-1:0]  bcnt_q, bcnt_d, qty_q, qty_d;
  logic [31:0]        shreg_q, shreg_d, rx_data_q, rx_data_d;
  logic               par_q, par_d, pce_q, pce_d;
  logic               rx_valid_q, rx_valid_d, wlc_q, wlc_d;
  logic               wrf_q, wrf_d, pef_q, pef_d, lef_q, lef_d, ovr_q, ovr_d;

  assign s0       = lines[0];
  assign s1       = lines[1];
  assign one_low  = s0 ^ s1;
  assign both_low = ~s0 & ~s1;
  assign rel      = line_q ? s1 : s0;
  assign pulse_ok = pcnt_q >= CNT_W'(MIN_PULSE);

  always_comb begin
    state_d    = state_q;
    line_d     = line_q;
    pcnt_d     = pcnt_q;
    gcnt_d     = gcnt_q;
    bcnt_d     = bcnt_q;
    qty_d      = qty_q;
    pce_d      = pce_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    wlc_d      = wlc_q;
    wrf_d      = clr_flags ? 1'b0 : wrf_q;
    pef_d      = clr_flags ? 1'b0 : pef_q;
    lef_d      = clr_flags ? 1'b0 : lef_q;
    ovr_d      = clr_flags ? 1'b0 : ovr_q;

    if (both_low && state_q != ST_ERR) begin
      state_d = ST_ERR;
      lef_d   = 1'b1;
      shreg_d = '0;
      par_d   = 1'b0;
      bcnt_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (one_low) begin
          state_d = ST_PULSE;
          line_d  = ~s1;
          pcnt_d  = CNT_W'(1);
        end
        ST_PULSE: begin
          if (!rel) begin
            if (pcnt_q != '1) pcnt_d = pcnt_q + 1'b1;
          end else if (pulse_ok) begin
            shreg_d = {shreg_q[30:0], line_q};
            par_d   = par_q ^ line_q;
            if (bcnt_q != '1) bcnt_d = bcnt_q + 1'b1;
            // Config is frozen at the first valid bit of each word.
            if (bcnt_q == '0) begin
              qty_d = cfg_bit_qty;
              pce_d = cfg_parity_en;
            end
            gcnt_d  = '0;
            state_d = ST_GAP;
          end else begin
            state_d = (bcnt_q != '0) ? ST_GAP : ST_IDLE;
          end
        end
        ST_GAP: begin
          if (one_low) begin
            state_d = ST_PULSE;
            line_d  = ~s1;
            pcnt_d  = CNT_W'(1);
          end else if (gcnt_q == CNT_W'(GAP_TIMEOUT)) begin
            rx_data_d  = shreg_q & low_mask(bcnt_q);
            rx_valid_d = 1'b1;
            wlc_d      = (bcnt_q == qty_q) && (qty_q <= BCNT_W'(32));
            pef_d      = pef_d | (pce_q & ~par_q);
            ovr_d      = ovr_d | wrf_q;
            wrf_d      = 1'b1;
            shreg_d    = '0;
            par_d      = 1'b0;
            bcnt_d     = '0;
            state_d    = ST_IDLE;
          end else if (gcnt_q != '1) begin
            gcnt_d = gcnt_q + 1'b1;
          end
        end
        ST_ERR: if (s0 && s1) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      line_q     <= 1'b0;
      pcnt_q     <= '0;
      gcnt_q     <= '0;
      bcnt_q     <= '0;
      qty_q      <= '0;
      pce_q      <= 1'b0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      wlc_q      <= 1'b0;
      wrf_q      <= 1'b0;
      pef_q      <= 1'b0;
      lef_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      pcnt_q     <= pcnt_d;
      gcnt_q     <= gcnt_d;
      bcnt_q     <= bcnt_d;
      qty_q      <= qty_d;
      pce_q      <= pce_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      wlc_q      <= wlc_d;
      wrf_q      <= wrf_d;
      pef_q      <= pef_d;
      lef_q      <= lef_d;
      ovr_q      <= ovr_d;
    end
  end

  assign wrp = (state_q == ST_GAP) || (state_q == ST_ERR) ||
               ((state_q == ST_PULSE) && ((bcnt_q != '0) || pulse_ok));

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign wlc      = wlc_q;
  assign wrf      = wrf_q;
  assign pef      = pef_q;
  assign lef      = lef_q;
  assign ovr      = ovr_q;

endmodule
